vp_text_serialize: RTL and testbench

//  Pipeline stage directly downstream of the text resize stage. Accepts one

---
 rtl/vp_text_serialize.sv | 115 +++++++++++
 tb/tb_vp_text_serialize.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_text_serialize.sv
// Text slice serializer: combines glyph/pattern/border into a 16-pixel word,
// applies blink/invert, and shifts one colour index per clock to the mixer.
module vp_text_serialize #(
   parameter int BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic        enable,
   input  logic [3:0]  txt_foreground,
   input  logic [3:0]  txt_background,
   input  logic [15:0] txt_char_row_bitmap,
   input  logic [15:0] txt_pattern,
   input  logic [15:0] txt_border,
   input  logic [1:0]  txt_func,
   input  logic        txt_blink,
   input  logic        txt_invert,
   output logic        ready,
   output logic [3:0]  pixel_color,
   output logic        pixel_valid,
   output logic        overrun,
   output logic        blink_phase
);

   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic [7:0]  blink_cnt_q;
   logic        blink_phase_q;
   logic [15:0] shift_q;
   logic [4:0]  count_q;
   logic [3:0]  fg_q;
   logic [3:0]  bg_q;
   logic [3:0]  color_q;
   logic        valid_q;
   logic        overrun_q;

   logic        load;
   logic [15:0] combine_d;
   logic [15:0] word_d;
   logic [3:0]  fg_d;
   logic [3:0]  bg_d;

   always_comb begin
      combine_d = txt_char_row_bitmap;
      case (txt_func)
         2'b00:   combine_d = txt_char_row_bitmap;
         2'b01:   combine_d = txt_char_row_bitmap | txt_pattern;
         2'b10:   combine_d = txt_char_row_bitmap ^ txt_pattern;
         default: combine_d = txt_char_row_bitmap & txt_pattern;
      endcase
      word_d = combine_d | txt_border;
      // Hidden blink phase blanks everything, border included.
      if (txt_blink && !blink_phase_q) begin
         word_d = 16'h0000;
      end
      fg_d = txt_invert ? txt_background : txt_foreground;
      bg_d = txt_invert ? txt_foreground : txt_background;
   end

   // count_q = pixels still to show, counting the one on pixel_color now.
   assign ready = (count_q == 5'd0) || (count_q == 5'd1);
   assign load  = enable && ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q   <= 8'd0;
         blink_phase_q <= 1'b1;
      end else if (frame_tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q   <= 16'h0000;
         count_q   <= 5'd0;
         fg_q      <= 4'h0;
         bg_q      <= 4'h0;
         color_q   <= 4'h0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (load) begin
            color_q <= word_d[15] ? fg_d : bg_d;
            shift_q <= {word_d[14:0], 1'b0};
            count_q <= 5'd16;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            valid_q <= 1'b1;
         end else if (count_q > 5'd1) begin
            color_q <= shift_q[15] ? fg_q : bg_q;
            shift_q <= {shift_q[14:0], 1'b0};
            count_q <= count_q - 5'd1;
            valid_q <= 1'b1;
         end else begin
            count_q <= 5'd0;
            valid_q <= 1'b0;
         end
         if (enable && !ready) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign pixel_color = color_q;
   assign pixel_valid = valid_q;
   assign overrun     = overrun_q;
   assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_vp_text_serialize.sv
// Randomized and directed bench for vp_text_serialize against a pixel-queue model.
module tb_vp_text_serialize;

   localparam int BF = 2;

   logic        clk;
   logic        reset;
   logic        frame_tick;
   logic        enable;
   logic [3:0]  txt_foreground;
   logic [3:0]  txt_background;
   logic [15:0] txt_char_row_bitmap;
   logic [15:0] txt_pattern;
   logic [15:0] txt_border;
   logic [1:0]  txt_func;
   logic        txt_blink;
   logic        txt_invert;
   logic        ready;
   logic [3:0]  pixel_color;
   logic        pixel_valid;
   logic        overrun;
   logic        blink_phase;

   vp_text_serialize #(.BLINK_FRAMES(BF)) dut (
      .clk                 (clk),
      .reset               (reset),
      .frame_tick          (frame_tick),
      .enable              (enable),
      .txt_foreground      (txt_foreground),
      .txt_background      (txt_background),
      .txt_char_row_bitmap (txt_char_row_bitmap),
      .txt_pattern         (txt_pattern),
      .txt_border          (txt_border),
      .txt_func            (txt_func),
      .txt_blink           (txt_blink),
      .txt_invert          (txt_invert),
      .ready               (ready),
      .pixel_color         (pixel_color),
      .pixel_valid         (pixel_valid),
      .overrun             (overrun),
      .blink_phase         (blink_phase)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive values
   logic        d_en, d_ft, d_blink, d_inv;
   logic [3:0]  d_fg, d_bg;
   logic [15:0] d_bmp, d_pat, d_bdr;
   logic [1:0]  d_func;

   // reference model: pixels not yet shown, plus visible output state
   logic [3:0]  exp_q[$];
   logic [3:0]  m_color;
   logic        m_valid;
   logic        m_overrun;
   int          m_ticks;

   int n_checks;
   int n_errors;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_phase();
      return ((m_ticks / BF) % 2) == 0;
   endfunction

   task automatic apply();
      enable              = d_en;
      frame_tick          = d_ft;
      txt_foreground      = d_fg;
      txt_background      = d_bg;
      txt_char_row_bitmap = d_bmp;
      txt_pattern         = d_pat;
      txt_border          = d_bdr;
      txt_func            = d_func;
      txt_blink           = d_blink;
      txt_invert          = d_inv;
   endtask

   task automatic idle_fields();
      d_en = 0; d_ft = 0; d_blink = 0; d_inv = 0;
      d_fg = 4'h0; d_bg = 4'h0; d_bmp = 16'h0; d_pat = 16'h0; d_bdr = 16'h0; d_func = 2'b00;
   endtask

   task automatic model_step();
      logic [15:0] w;
      logic [3:0]  f, b;
      logic        rdy;
      rdy = (exp_q.size() == 0);
      if (d_en && rdy) begin
         case (d_func)
            2'b00: w = d_bmp;
            2'b01: w = d_bmp | d_pat;
            2'b10: w = d_bmp ^ d_pat;
            default: w = d_bmp & d_pat;
         endcase
         w = w | d_bdr;
         if (d_blink && !model_phase()) w = 16'h0000;
         f = d_inv ? d_bg : d_fg;
         b = d_inv ? d_fg : d_bg;
         for (int i = 15; i >= 0; i--) exp_q.push_back(w[i] ? f : b);
      end else if (d_en) begin
         m_overrun = 1'b1;
      end
      if (d_ft) m_ticks++;
      if (exp_q.size() > 0) begin
         m_color = exp_q.pop_front();
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   // Entered just after a rising edge; returns just after the next one.
   task automatic cyc();
      apply();
      @(negedge clk);
      check("ready", 16'(ready), 16'(exp_q.size() == 0));
      check("pixel_valid", 16'(pixel_valid), 16'(m_valid));
      check("pixel_color", 16'(pixel_color), 16'(m_color));
      check("overrun", 16'(overrun), 16'(m_overrun));
      check("blink_phase", 16'(blink_phase), 16'(model_phase()));
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         idle_fields();
         cyc();
      end
   endtask

   task automatic load(input logic [15:0] bmp, input logic [15:0] pat, input logic [15:0] bdr,
                       input logic [1:0] func, input logic [3:0] fg, input logic [3:0] bg,
                       input logic blink, input logic inv, input logic ft);
      idle_fields();
      d_en = 1; d_bmp = bmp; d_pat = pat; d_bdr = bdr; d_func = func;
      d_fg = fg; d_bg = bg; d_blink = blink; d_inv = inv; d_ft = ft;
      cyc();
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         idle_fields();
         d_ft = 1;
         cyc();
      end
   endtask

   task automatic do_reset();
      idle_fields();
      apply();
      reset = 1'b1;
      #2;
      check("rst_valid", 16'(pixel_valid), 16'h0);
      check("rst_color", 16'(pixel_color), 16'h0);
      check("rst_overrun", 16'(overrun), 16'h0);
      check("rst_phase", 16'(blink_phase), 16'h1);
      check("rst_ready", 16'(ready), 16'h1);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      m_color = 4'h0; m_valid = 1'b0; m_overrun = 1'b0; m_ticks = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      idle_fields();
      apply();
      #1;
      do_reset();

      // basic slice F00F
      load(16'hF00F, 16'h0, 16'h0, 2'b00, 4'hA, 4'h3, 0, 0, 0);
      idle(18);

      // back-to-back FFFF then 0000
      load(16'hFFFF, 16'h0, 16'h0, 2'b00, 4'h5, 4'hC, 0, 0, 0);
      idle(15);
      load(16'h0000, 16'h0, 16'h0, 2'b00, 4'h5, 4'hC, 0, 0, 0);
      idle(17);

      // func sweep, then border on func 11
      for (int f = 0; f < 4; f++) begin
         load(16'hFF00, 16'hF0F0, 16'h0, 2'(f), 4'h9, 4'h6, 0, 0, 0);
         idle(15);
      end
      load(16'hFF00, 16'hF0F0, 16'h0001, 2'b11, 4'h9, 4'h6, 0, 0, 0);
      idle(17);

      // invert
      load(16'h8000, 16'h0, 16'h0, 2'b00, 4'h1, 4'h2, 0, 1, 0);
      idle(17);

      // blink: hide after BF ticks, show after BF more; load on a tick edge
      tick(BF);
      load(16'hFFFF, 16'h0, 16'h00F0, 2'b00, 4'hE, 4'h4, 1, 0, 0);
      idle(16);
      tick(BF - 1);
      load(16'hFFFF, 16'h0, 16'h0, 2'b00, 4'hE, 4'h4, 1, 0, 1);
      idle(16);
      load(16'hFFFF, 16'h0, 16'h0, 2'b00, 4'hE, 4'h4, 1, 0, 0);
      idle(17);

      // drop mid-slice, then reset mid-slice
      load(16'hA5C3, 16'h0, 16'h0, 2'b00, 4'h7, 4'h8, 0, 0, 0);
      idle(7);
      load(16'hFFFF, 16'h0, 16'h0, 2'b00, 4'hF, 4'hF, 0, 0, 0);
      idle(10);
      load(16'h1234, 16'h0, 16'h0, 2'b01, 4'hB, 4'hD, 0, 0, 0);
      idle(10);
      do_reset();
      idle(2);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         d_en    = ($urandom_range(0, 5) == 0) || (exp_q.size() == 0 && $urandom_range(0, 1) == 0);
         d_ft    = ($urandom_range(0, 3) == 0);
         d_fg    = 4'($urandom);
         d_bg    = 4'($urandom);
         d_bmp   = 16'($urandom);
         d_pat   = 16'($urandom);
         d_bdr   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
         d_func  = 2'($urandom);
         d_blink = 1'($urandom);
         d_inv   = 1'($urandom);
         cyc();
      end
      idle(18);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
